// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: divided clock, start-of-period tick, divisor handshake.
// Define CLKDIV_SYNC_EN to add the sync_in phase-restart input.
module clk_div_prog #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DIV_DEFAULT = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             active,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ZERO    = '0;
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] n_act_q, n_act_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;

    logic [CNT_W-1:0] hi_last;
    logic             at_wrap;
    logic             at_hi_last;
    logic             sync_req;
    logic             restart;
    logic             apply_pend;
    logic             xfer;

    // Last high-phase count is ceil(N/2)-1; written without N+1 so N=2^CNT_W-1 cannot overflow.
    assign hi_last    = (n_act_q >> 1) + CNT_W'(n_act_q[0]) - ONE;
    assign at_wrap    = (cnt_q == n_act_q - ONE);
    assign at_hi_last = (cnt_q == hi_last);

`ifdef CLKDIV_SYNC_EN
    assign sync_req = sync_in;
`else
    assign sync_req = 1'b0;
`endif

    assign restart   = sync_req || (at_wrap && en);
    assign div_ready = !pend_vld_q;
    assign xfer      = div_valid && div_ready;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_act_d    = n_act_q;
        pend_val_d = pend_val_q;
        pend_vld_d = pend_vld_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        cfg_err_d  = 1'b0;
        apply_pend = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = ZERO;
                clk_d      = 1'b0;
                apply_pend = pend_vld_q;
                if (en) begin
                    state_d = ST_RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                end
            end

            ST_RUN, ST_STOPPING: begin
                if (restart) begin
                    // Period boundary: the only place a new divisor may take effect while running.
                    cnt_d      = ZERO;
                    clk_d      = 1'b1;
                    tick_d     = 1'b1;
                    apply_pend = pend_vld_q;
                    state_d    = en ? ST_RUN : ST_STOPPING;
                end else if (at_wrap) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d   = cnt_q + ONE;
                    state_d = en ? ST_RUN : ST_STOPPING;
                    if (at_hi_last) begin
                        clk_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = ZERO;
                clk_d   = 1'b0;
            end
        endcase

        if (apply_pend) begin
            n_act_d    = pend_val_q;
            pend_vld_d = 1'b0;
        end

        // A transfer can only happen with no pending value, so it never collides with apply_pend.
        if (xfer) begin
            if (div_in >= TWO) begin
                pend_val_d = div_in;
                pend_vld_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= ZERO;
            n_act_q    <= DIV_RST;
            pend_val_q <= ZERO;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_act_q    <= n_act_d;
            pend_val_q <= pend_val_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign cfg_err = cfg_err_q;
    assign active  = (state_q != ST_IDLE);

`ifndef SYNTHESIS
    a_cnt_range: assert property (@(posedge clk_in) disable iff (!rst_n) cnt_q < n_act_q);
    a_div_legal: assert property (@(posedge clk_in) disable iff (!rst_n) n_act_q >= TWO);
    a_tick_high: assert property (@(posedge clk_in) disable iff (!rst_n) tick_q |-> clk_q);
    a_tick_run:  assert property (@(posedge clk_in) disable iff (!rst_n) tick_q |-> active);
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed period tables, hand-written corner sequences,
// and randomized stimulus compared every cycle against a phase-position reference model.
module tb_clk_div_prog;

    localparam int CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             rst_n;
    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_valid;
    logic             div_ready;
    logic             clk_out;
    logic             tick;
    logic             active;
    logic             cfg_err;
`ifdef CLKDIV_SYNC_EN
    logic             sync_in;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Reference model: running flag, position inside the period, active and pending divisor.
    bit m_run;
    bit m_pend;
    bit m_err;
    int m_pos;
    int m_n;
    int m_pv;

    typedef struct {
        logic [CNT_W-1:0] n;
        int               hi;
        int               lo;
    } vec_t;

    vec_t vt[6];

    clk_div_prog #(
        .CNT_W      (CNT_W),
        .DIV_DEFAULT(16)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .div_in   (div_in),
        .div_valid(div_valid),
        .div_ready(div_ready),
`ifdef CLKDIV_SYNC_EN
        .sync_in  (sync_in),
`endif
        .clk_out  (clk_out),
        .tick     (tick),
        .active   (active),
        .cfg_err  (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, required %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_pend = 1'b0;
        m_err  = 1'b0;
        m_pos  = 0;
        m_n    = 16;
        m_pv   = 0;
    endtask

    task automatic model_step();
        bit rdy_old;
        bit sy;
        rdy_old = !m_pend;
        sy      = 1'b0;
`ifdef CLKDIV_SYNC_EN
        sy = sync_in;
`endif
        m_err = 1'b0;
        if (!m_run) begin
            if (m_pend) begin
                m_n    = m_pv;
                m_pend = 1'b0;
            end
            if (en) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (sy || (m_pos == m_n - 1)) begin
            if (sy || en) begin
                m_pos = 0;
                if (m_pend) begin
                    m_n    = m_pv;
                    m_pend = 1'b0;
                end
            end else begin
                m_run = 1'b0;
                m_pos = 0;
            end
        end else begin
            m_pos++;
        end
        if (div_valid && rdy_old) begin
            if (int'(div_in) >= 2) begin
                m_pend = 1'b1;
                m_pv   = int'(div_in);
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic model_check();
        logic e_clk;
        logic e_tick;
        e_clk  = m_run && (m_pos < (m_n + 1) / 2);
        e_tick = m_run && (m_pos == 0);
        check_bit("model_clk_out", clk_out, e_clk);
        check_bit("model_tick", tick, e_tick);
        check_bit("model_active", active, m_run);
        check_bit("model_div_ready", div_ready, !m_pend);
        check_bit("model_cfg_err", cfg_err, m_err);
    endtask

    task automatic cyc();
        @(posedge clk_in);
        if (!rst_n) model_reset();
        else        model_step();
        #1;
        model_check();
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            n++;
            if (tick) return;
        end
        check_bit("wait_tick_timeout", tick, 1'b1);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            n++;
            if (div_ready) return;
        end
        check_bit("wait_ready_timeout", div_ready, 1'b1);
    endtask

    // Call on a tick sample; counts high and low samples until the next tick.
    task automatic measure(output int hi, output int lo);
        hi = 0;
        lo = 0;
        for (int i = 0; i < 400; i++) begin
            if (clk_out) hi++;
            else         lo++;
            cyc();
            if (tick) return;
        end
        check_bit("measure_timeout", tick, 1'b1);
    endtask

    task automatic load(input logic [CNT_W-1:0] n);
        int dummy;
        if (!div_ready) wait_ready(dummy);
        div_in    = n;
        div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        check_bit("load_ready_low", div_ready, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_bit("arst_clk_out", clk_out, 1'b0);
        check_bit("arst_active", active, 1'b0);
        check_bit("arst_div_ready", div_ready, 1'b1);
        check_bit("arst_tick", tick, 1'b0);
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        int lo;
        int n;

        vt[0] = '{CNT_W'(2),  1, 1};
        vt[1] = '{CNT_W'(3),  2, 1};
        vt[2] = '{CNT_W'(4),  2, 2};
        vt[3] = '{CNT_W'(7),  4, 3};
        vt[4] = '{CNT_W'(16), 8, 8};
        vt[5] = '{CNT_W'(8),  4, 4};

        rst_n     = 1'b0;
        en        = 1'b0;
        div_in    = '0;
        div_valid = 1'b0;
`ifdef CLKDIV_SYNC_EN
        sync_in   = 1'b0;
`endif
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        check_bit("rst_clk_out", clk_out, 1'b0);
        check_bit("rst_tick", tick, 1'b0);
        check_bit("rst_active", active, 1'b0);
        check_bit("rst_div_ready", div_ready, 1'b1);
        check_bit("rst_cfg_err", cfg_err, 1'b0);

        // Default divisor: tick one cycle after en, 8 high / 8 low, repeating.
        en = 1'b1;
        cyc();
        check_bit("start_tick", tick, 1'b1);
        check_bit("start_clk_out", clk_out, 1'b1);
        check_bit("start_active", active, 1'b1);
        for (int k = 0; k < 2; k++) begin
            measure(hi, lo);
            check_int("default_hi", hi, 8);
            check_int("default_lo", lo, 8);
        end

        // Illegal divisors are rejected with a one-cycle cfg_err and leave N_act alone.
        for (int v = 0; v < 2; v++) begin
            div_in    = CNT_W'(v);
            div_valid = 1'b1;
            cyc();
            div_valid = 1'b0;
            check_bit("bad_div_cfg_err", cfg_err, 1'b1);
            check_bit("bad_div_ready", div_ready, 1'b1);
            cyc();
            check_bit("bad_div_cfg_err_clear", cfg_err, 1'b0);
        end
        wait_tick(n);
        measure(hi, lo);
        check_int("bad_div_keep_hi", hi, 8);
        check_int("bad_div_keep_lo", lo, 8);

        // Divisor 5 loaded at cnt=4: current period completes, ready returns at the new tick.
        cyc(); cyc(); cyc(); cyc();
        load(CNT_W'(5));
        wait_ready(n);
        check_int("mid_load_ready_delay", n, 11);
        check_bit("mid_load_tick", tick, 1'b1);
        measure(hi, lo);
        check_int("div5_hi", hi, 3);
        check_int("div5_lo", lo, 2);

        // A held div_valid while not ready must not overwrite the pending value.
        div_in    = CNT_W'(9);
        div_valid = 1'b1;
        cyc();
        div_in = CNT_W'(12);
        wait_ready(n);
        div_valid = 1'b0;
        measure(hi, lo);
        check_int("no_overwrite_hi", hi, 5);
        check_int("no_overwrite_lo", lo, 4);

        for (int i = 0; i < 6; i++) begin
            load(vt[i].n);
            wait_ready(n);
            check_bit("table_tick", tick, 1'b1);
            measure(hi, lo);
            check_int("table_hi", hi, vt[i].hi);
            check_int("table_lo", lo, vt[i].lo);
        end

        // Transfer on the wrap cycle takes effect one period later.
        load(CNT_W'(2));
        wait_ready(n);
        cyc();
        div_in    = CNT_W'(3);
        div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        wait_ready(n);
        check_int("wrap_xfer_delay", n, 2);
        measure(hi, lo);
        check_int("wrap_xfer_hi", hi, 2);
        check_int("wrap_xfer_lo", lo, 1);

        // Stop with N=8, en dropped at cnt=3: full 4/4 period, then idle without ticks.
        load(CNT_W'(8));
        wait_ready(n);
        hi = 0;
        lo = 0;
        for (int i = 0; i < 40; i++) begin
            if (clk_out) hi++;
            else         lo++;
            if (i == 3) en = 1'b0;
            cyc();
            if (!active) break;
        end
        check_int("stop_hi", hi, 4);
        check_int("stop_lo", lo, 4);
        check_bit("stop_active", active, 1'b0);
        check_bit("stop_clk_out", clk_out, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc();
            check_bit("idle_no_tick", tick, 1'b0);
        end

        // Reset mid-high with a pending divisor: immediate clear, N back to 16.
        en = 1'b1;
        cyc();
        cyc();
        load(CNT_W'(6));
        check_bit("pre_reset_high", clk_out, 1'b1);
        async_reset();
        wait_tick(n);
        check_int("post_reset_start", n, 1);
        measure(hi, lo);
        check_int("post_reset_hi", hi, 8);
        check_int("post_reset_lo", lo, 8);

`ifdef CLKDIV_SYNC_EN
        // Phase restart at cnt=6 with N=10.
        load(CNT_W'(10));
        wait_ready(n);
        for (int i = 0; i < 6; i++) cyc();
        sync_in = 1'b1;
        cyc();
        sync_in = 1'b0;
        check_bit("sync_tick", tick, 1'b1);
        check_bit("sync_clk_out", clk_out, 1'b1);
        measure(hi, lo);
        check_int("sync_hi", hi, 5);
        check_int("sync_lo", lo, 5);
`endif

        for (int i = 0; i < 800; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            div_valid = ($urandom_range(0, 4) == 0);
            div_in    = CNT_W'($urandom_range(0, 12));
`ifdef CLKDIV_SYNC_EN
            sync_in   = ($urandom_range(0, 30) == 0);
`endif
            if (i == 400) async_reset();
            else          cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
